// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo (slave).
// The flush strobe travels with the data path because it is issued by the same
// agent that drives wr_en/rd_en.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic                  clear;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  wr_full;
   logic                  wr_almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_empty;
   logic                  rd_almost_empty;
   logic [ADDR_WIDTH:0]   level;
   logic                  overflow;
   logic                  underflow;

   // User side: issues requests, observes data and status.
   modport master (
      output clear, wr_data, wr_en, rd_en,
      input  wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
             level, overflow, underflow
   );

   // FIFO side: accepts requests, reports data and status.
   modport slave (
      input  clear, wr_data, wr_en, rd_en,
      output wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
             level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered fill counter driving exact status flags.
// Storage is a plain synchronous-write / registered-read array so it maps onto
// block RAM. FWFT=0 gives a one-cycle registered read; FWFT=1 adds a prefetch
// output register so the head word is always on rd_data while rd_empty=0.
// level always counts every word held, including the FWFT output register.
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter bit FWFT       = 1'b0,
   parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 4,
   parameter int AE_LEVEL   = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   sync_fifo_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LVL_W = ADDR_WIDTH + 1;

   typedef logic [ADDR_WIDTH-1:0] ptr_t;
   typedef logic [LVL_W-1:0]      lvl_t;
   typedef logic [DATA_WIDTH-1:0] word_t;

   localparam lvl_t LVL_DEPTH = lvl_t'(DEPTH);
   localparam lvl_t LVL_AF    = lvl_t'(AF_LEVEL);
   localparam lvl_t LVL_AE    = lvl_t'(AE_LEVEL);

   word_t mem [DEPTH];

   ptr_t  wr_ptr_q;
   ptr_t  rd_ptr_q;
   lvl_t  level_q;
   word_t rd_data_q;
   logic  out_valid_q;
   logic  wr_full_q;
   logic  wr_almost_full_q;
   logic  rd_empty_q;
   logic  rd_almost_empty_q;
   logic  overflow_q;
   logic  underflow_q;

   logic  wr_accept;
   logic  rd_accept;
   logic  ram_rd;
   lvl_t  ram_count;
   lvl_t  level_next;
   logic  out_valid_next;
   logic  rd_empty_next;

   // Decide which requests are accepted this cycle and derive next-state level,
   // the RAM read strobe and the output-register valid bit.
   // NOTE: every output of an always_comb gets a default first so that no path
   // leaves a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_accept      = bus.wr_en && !wr_full_q;
      rd_accept      = bus.rd_en && !rd_empty_q;
      ram_count      = level_q - lvl_t'(out_valid_q);
      level_next     = level_q;
      out_valid_next = out_valid_q;
      ram_rd         = 1'b0;
      rd_empty_next  = 1'b1;

      if (wr_accept && !rd_accept) begin
         level_next = level_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
         level_next = level_q - 1'b1;
      end

      if (FWFT) begin
         // Refill the output register when it is empty or being popped, using
         // only words already in RAM before this edge (hence the 2-edge latency).
         ram_rd = (ram_count != '0) && (!out_valid_q || rd_accept);
         if (ram_rd) begin
            out_valid_next = 1'b1;
         end else if (rd_accept) begin
            out_valid_next = 1'b0;
         end
         rd_empty_next = !out_valid_next;
      end else begin
         ram_rd        = rd_accept;
         rd_empty_next = (level_next == '0);
      end
   end

   // Pointers, fill counter and FWFT valid bit; clear wins over any request.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (ram_rd) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         level_q     <= level_next;
         out_valid_q <= out_valid_next;
      end
   end

   // Status flags decoded from next-state level so they change on the same
   // edge as level itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_full_q         <= 1'b0;
         wr_almost_full_q  <= 1'b0;
         rd_empty_q        <= 1'b1;
         rd_almost_empty_q <= 1'b1;
      end else if (bus.clear) begin
         wr_full_q         <= 1'b0;
         wr_almost_full_q  <= 1'b0;
         rd_empty_q        <= 1'b1;
         rd_almost_empty_q <= 1'b1;
      end else begin
         wr_full_q         <= (level_next == LVL_DEPTH);
         wr_almost_full_q  <= (level_next >= LVL_AF);
         rd_empty_q        <= rd_empty_next;
         rd_almost_empty_q <= (level_next <= LVL_AE);
      end
   end

   // Sticky error flags: a rejected request leaves a mark until reset or clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.clear) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q  | (bus.wr_en & wr_full_q);
         underflow_q <= underflow_q | (bus.rd_en & rd_empty_q);
      end
   end

   // Read data register: loads the word at rd_ptr on each RAM read and holds
   // otherwise, so a pop never blanks rd_data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= '0;
      end else if (bus.clear) begin
         rd_data_q <= '0;
      end else if (ram_rd) begin
         rd_data_q <= mem[rd_ptr_q];
      end
   end

   // RAM write port. A read and an accepted write never address the same slot:
   // reads need level > 0 and writes need level < DEPTH, so wr_ptr != rd_ptr.
   // NOTE: the storage array has no reset; clearing it would prevent block-RAM
   // mapping and is unnecessary because level gates every read.
   always_ff @(posedge clk) begin
      if (wr_accept && !bus.clear) begin
         mem[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.wr_full         = wr_full_q;
   assign bus.wr_almost_full  = wr_almost_full_q;
   assign bus.rd_data         = rd_data_q;
   assign bus.rd_empty        = rd_empty_q;
   assign bus.rd_almost_empty = rd_almost_empty_q;
   assign bus.level           = level_q;
   assign bus.overflow        = overflow_q;
   assign bus.underflow       = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one registered-read and one FWFT instance see the same
// stimulus. A word-list model per instance predicts every output each cycle;
// directed steps add hand-computed literal expectations.
module tb_sync_fifo;

   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int DEPTH = 512;
   localparam int AF    = DEPTH - 4;
   localparam int AE    = 4;
   localparam int MBUF  = 1024;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b0;
   logic          s_clear   = 1'b0;
   logic          s_wr_en   = 1'b0;
   logic          s_rd_en   = 1'b0;
   logic [DW-1:0] s_wr_data = '0;
   logic          chk_en    = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.clear   = s_clear;
   assign bus0.wr_en   = s_wr_en;
   assign bus0.wr_data = s_wr_data;
   assign bus0.rd_en   = s_rd_en;
   assign bus1.clear   = s_clear;
   assign bus1.wr_en   = s_wr_en;
   assign bus1.wr_data = s_wr_data;
   assign bus1.rd_en   = s_rd_en;

   sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0)) dut_reg (
      .clk(clk), .reset_n(reset_n), .bus(bus0)
   );
   sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1)) dut_fwft (
      .clk(clk), .reset_n(reset_n), .bus(bus1)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model (index 0 = registered, 1 = FWFT) -----
   logic [DW-1:0] m_data  [2][MBUF];
   int            m_tag   [2][MBUF];
   int            m_head  [2];
   int            m_cnt   [2];
   logic          m_ovf   [2];
   logic          m_unf   [2];
   logic [DW-1:0] m_shown [2];
   int            cyc = 0;

   // A word is readable in FWFT mode once it has aged one full edge past the
   // edge that wrote it; in registered mode any held word is readable.
   function automatic bit m_visible(input int m);
      if (m_cnt[m] == 0) return 1'b0;
      if (m == 0) return 1'b1;
      return (m_tag[m][m_head[m]] + 2) <= cyc;
   endfunction

   task automatic m_reset(input int m);
      m_head[m]  = 0;
      m_cnt[m]   = 0;
      m_ovf[m]   = 1'b0;
      m_unf[m]   = 1'b0;
      m_shown[m] = '0;
   endtask

   always @(posedge clk or negedge reset_n) begin
      bit full_b;
      bit empty_b;
      if (!reset_n) begin
         m_reset(0);
         m_reset(1);
      end else begin
         for (int m = 0; m < 2; m++) begin
            full_b  = (m_cnt[m] == DEPTH);
            empty_b = !m_visible(m);
            if (s_clear) begin
               m_reset(m);
            end else begin
               if (s_wr_en && full_b)  m_ovf[m] = 1'b1;
               if (s_rd_en && empty_b) m_unf[m] = 1'b1;
               if (s_rd_en && !empty_b) begin
                  if (m == 0) m_shown[m] = m_data[m][m_head[m]];
                  m_head[m] = (m_head[m] + 1) % MBUF;
                  m_cnt[m]  = m_cnt[m] - 1;
               end
               if (s_wr_en && !full_b) begin
                  m_data[m][(m_head[m] + m_cnt[m]) % MBUF] = s_wr_data;
                  m_tag[m][(m_head[m] + m_cnt[m]) % MBUF]  = cyc;
                  m_cnt[m] = m_cnt[m] + 1;
               end
            end
         end
         cyc = cyc + 1;
         if (m_visible(1)) m_shown[1] = m_data[1][m_head[1]];
      end
   end

   // ---------------- checking -----------------------------------------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_dut(input int m, input logic [DW-1:0] rdd, input logic emp,
                              input logic ae, input logic full, input logic af,
                              input logic ovf, input logic unf, input logic [AW:0] lvl);
      string p;
      p = (m == 0) ? "reg" : "fwft";
      check({p, ".level"},           64'(lvl),  64'(m_cnt[m]));
      check({p, ".wr_full"},         64'(full), 64'(m_cnt[m] == DEPTH));
      check({p, ".wr_almost_full"},  64'(af),   64'(m_cnt[m] >= AF));
      check({p, ".rd_almost_empty"}, 64'(ae),   64'(m_cnt[m] <= AE));
      check({p, ".rd_empty"},        64'(emp),  64'(!m_visible(m)));
      check({p, ".rd_data"},         64'(rdd),  64'(m_shown[m]));
      check({p, ".overflow"},        64'(ovf),  64'(m_ovf[m]));
      check({p, ".underflow"},       64'(unf),  64'(m_unf[m]));
   endtask

   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         compare_dut(0, bus0.rd_data, bus0.rd_empty, bus0.rd_almost_empty, bus0.wr_full,
                     bus0.wr_almost_full, bus0.overflow, bus0.underflow, bus0.level);
         compare_dut(1, bus1.rd_data, bus1.rd_empty, bus1.rd_almost_empty, bus1.wr_full,
                     bus1.wr_almost_full, bus1.overflow, bus1.underflow, bus1.level);
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
      s_wr_en   = wr;
      s_wr_data = d;
      s_rd_en   = rd;
      s_clear   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".reg.level"},       64'(bus0.level),           64'd0);
      check({tag, ".fwft.level"},      64'(bus1.level),           64'd0);
      check({tag, ".reg.rd_empty"},    64'(bus0.rd_empty),        64'd1);
      check({tag, ".fwft.rd_empty"},   64'(bus1.rd_empty),        64'd1);
      check({tag, ".reg.ae"},          64'(bus0.rd_almost_empty), 64'd1);
      check({tag, ".fwft.af"},         64'(bus1.wr_almost_full),  64'd0);
      check({tag, ".reg.full"},        64'(bus0.wr_full),         64'd0);
      check({tag, ".fwft.overflow"},   64'(bus1.overflow),        64'd0);
      check({tag, ".reg.underflow"},   64'(bus0.underflow),       64'd0);
   endtask

   // Runaway guard: the directed sequence is a few thousand cycles.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at t=%0t, limit 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence --------------------------------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk_en  = 1'b1;
      check_reset_state("post_reset");
      check("post_reset.reg.rd_data", 64'(bus0.rd_data), 64'd0);

      // FWFT latency: write at edge N, visible after N+1; registered needs a read.
      drive(1'b1, 32'hA5, 1'b0, 1'b0);
      check("wr_a5.reg.rd_empty",  64'(bus0.rd_empty), 64'd0);
      check("wr_a5.fwft.rd_empty", 64'(bus1.rd_empty), 64'd1);
      check("wr_a5.fwft.level",    64'(bus1.level),    64'd1);
      idle();
      check("n1.fwft.rd_empty", 64'(bus1.rd_empty), 64'd0);
      check("n1.fwft.rd_data",  64'(bus1.rd_data),  64'hA5);
      check("n1.reg.rd_data",   64'(bus0.rd_data),  64'd0);
      drive(1'b0, '0, 1'b1, 1'b0);
      check("pop_a5.reg.rd_data",   64'(bus0.rd_data),  64'hA5);
      check("pop_a5.fwft.rd_data",  64'(bus1.rd_data),  64'hA5);
      check("pop_a5.fwft.rd_empty", 64'(bus1.rd_empty), 64'd1);

      // Simultaneous read and write at level 0: write lands, read is refused.
      drive(1'b1, 32'h11, 1'b1, 1'b0);
      check("rw0.reg.level",      64'(bus0.level),     64'd1);
      check("rw0.fwft.level",     64'(bus1.level),     64'd1);
      check("rw0.reg.underflow",  64'(bus0.underflow), 64'd1);
      check("rw0.fwft.underflow", 64'(bus1.underflow), 64'd1);
      check("rw0.reg.rd_data",    64'(bus0.rd_data),   64'hA5);
      drive(1'b0, '0, 1'b0, 1'b1);
      check_reset_state("clear1");

      // Fill to full, then one rejected write.
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, DW'(i), 1'b0, 1'b0);
         if (i + 1 == AF - 1) check("fill507.reg.af",  64'(bus0.wr_almost_full), 64'd0);
         if (i + 1 == AF)     check("fill508.fwft.af", 64'(bus1.wr_almost_full), 64'd1);
         if (i + 1 == DEPTH - 1) check("fill511.reg.full", 64'(bus0.wr_full), 64'd0);
      end
      check("fill512.reg.full",  64'(bus0.wr_full), 64'd1);
      check("fill512.fwft.full", 64'(bus1.wr_full), 64'd1);
      drive(1'b1, 32'd999, 1'b0, 1'b0);
      check("ovf.reg.overflow",  64'(bus0.overflow), 64'd1);
      check("ovf.fwft.overflow", 64'(bus1.overflow), 64'd1);
      check("ovf.reg.level",     64'(bus0.level),    64'd512);

      // Drain: registered data arrives one cycle after rd_en; FWFT streams
      // the head word with no bubbles.
      for (int i = 0; i < DEPTH; i++) begin
         check("drain.fwft.rd_empty", 64'(bus1.rd_empty), 64'd0);
         check("drain.fwft.rd_data",  64'(bus1.rd_data),  64'(i));
         drive(1'b0, '0, 1'b1, 1'b0);
         check("drain.reg.rd_data",   64'(bus0.rd_data),  64'(i));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      check("unf.reg.underflow",  64'(bus0.underflow), 64'd1);
      check("unf.fwft.underflow", 64'(bus1.underflow), 64'd1);
      check("unf.reg.overflow",   64'(bus0.overflow),  64'd1);
      check("unf.reg.rd_data",    64'(bus0.rd_data),   64'd511);
      drive(1'b0, '0, 1'b0, 1'b1);
      check_reset_state("clear2");

      // Asynchronous reset in the middle of a cycle at level 37.
      for (int i = 0; i < 37; i++) drive(1'b1, DW'(1000 + i), 1'b0, 1'b0);
      idle();
      check("pre_rst.reg.level",  64'(bus0.level), 64'd37);
      check("pre_rst.fwft.level", 64'(bus1.level), 64'd37);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Steady read+write at level 256 across many pointer wraps.
      for (int i = 0; i < 256; i++) drive(1'b1, DW'(5000 + i), 1'b0, 1'b0);
      idle();
      for (int k = 0; k < 1000; k++) begin
         drive(1'b1, DW'(5256 + k), 1'b1, 1'b0);
         check("steady.reg.level",  64'(bus0.level), 64'd256);
         check("steady.fwft.level", 64'(bus1.level), 64'd256);
      end
      check("steady.reg.rd_data",  64'(bus0.rd_data), 64'd5999);
      check("steady.fwft.rd_data", 64'(bus1.rd_data), 64'd6000);
      idle();

      // Flush at level 300 while a write is requested: the write is discarded.
      drive(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
      idle();
      check("pre_clr.reg.level", 64'(bus0.level), 64'd300);
      drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
      check_reset_state("clear3");
      idle();
      check("post_clr.reg.level",     64'(bus0.level),    64'd0);
      check("post_clr.fwft.level",    64'(bus1.level),    64'd0);
      check("post_clr.fwft.rd_empty", 64'(bus1.rd_empty), 64'd1);

      idle();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
